// File: rtl/expr_result_unpacker.sv
// expr_result_unpacker: serialises a packed 90-bit vloghammer result word into 18 sign/zero-extended 8-bit fields.
// Define EXPR_UNPACK_SIG_EN to build the per-word 16-bit rotate-xor signature on sig/sig_valid.
module expr_result_unpacker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [89:0] in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_field,
    output logic [4:0]  out_idx,
    output logic        out_signed,
    output logic        out_last,
    output logic [15:0] sig,
    output logic        sig_valid
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state, state_nx;
    logic [89:0] sh, sh_nx;
    logic [4:0] idx, idx_nx;
    logic [1:0] ph, ph_nx;
    logic grp, grp_nx, fire, load, lastf;
    logic [7:0] field;
    // ph tracks idx%3 (field width 4/5/6); grp tracks odd groups of three, which are signed
    assign out_valid = state == EMIT;
    assign lastf = idx == 5'd17;
    assign fire = out_valid && out_ready;
    assign in_ready = state == IDLE || (fire && lastf);
    assign load = in_valid && in_ready;
    assign field = ph == 2'd0 ? {{4{grp & sh[89]}}, sh[89:86]} :
                   ph == 2'd1 ? {{3{grp & sh[89]}}, sh[89:85]} :
                                {{2{grp & sh[89]}}, sh[89:84]};
    assign out_field = out_valid ? field : 8'h00;
    assign out_idx = out_valid ? idx : 5'd0;
    assign out_signed = out_valid && grp;
    assign out_last = out_valid && lastf;
    always_comb begin
        state_nx = state;
        sh_nx = sh;
        idx_nx = idx;
        ph_nx = ph;
        grp_nx = grp;
        if (load) begin
            state_nx = EMIT;
            sh_nx = in_y;
            idx_nx = 5'd0;
            ph_nx = 2'd0;
            grp_nx = 1'b0;
        end else if (fire && lastf) begin
            state_nx = IDLE;
        end else if (fire) begin
            sh_nx = ph == 2'd0 ? sh << 4 : ph == 2'd1 ? sh << 5 : sh << 6;
            idx_nx = idx + 5'd1;
            ph_nx = ph == 2'd2 ? 2'd0 : ph + 2'd1;
            grp_nx = ph == 2'd2 ? ~grp : grp;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh <= '0;
            idx <= '0;
            ph <= '0;
            grp <= 1'b0;
        end else begin
            state <= state_nx;
            sh <= sh_nx;
            idx <= idx_nx;
            ph <= ph_nx;
            grp <= grp_nx;
        end
    end
`ifdef EXPR_UNPACK_SIG_EN
    logic [15:0] acc, acc_nx;
    assign acc_nx = {acc[14:0], acc[15]} ^ {8'h00, field};
    // a reload on the last handshake clears acc while sig still captures the finished word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sig <= '0;
            sig_valid <= 1'b0;
        end else begin
            sig_valid <= fire && lastf;
            if (load) acc <= '0;
            else if (fire) acc <= acc_nx;
            if (fire && lastf) sig <= acc_nx;
        end
    end
`else
    assign sig = 16'h0000;
    assign sig_valid = 1'b0;
`endif
endmodule

// File: tb/tb_expr_result_unpacker.sv
// tb_expr_result_unpacker: scoreboard bench; directed words push expected fields, a monitor checks every handshake.
module tb_expr_result_unpacker;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [89:0] in_y = '0;
    logic in_ready, out_valid, out_signed, out_last, sig_valid;
    logic [7:0] out_field;
    logic [4:0] out_idx;
    logic [15:0] sig;
    typedef struct packed {logic [7:0] f; logic [4:0] i; logic s; logic l;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, cyc = 0, last_cyc = 0, pulses = 0;
    logic [7:0] ef [18];
    logic [7:0] ones_pat [6] = '{8'h0F, 8'h1F, 8'h3F, 8'hFF, 8'hFF, 8'hFF};

    expr_result_unpacker dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
        .out_idx(out_idx), .out_signed(out_signed), .out_last(out_last), .sig(sig), .sig_valid(sig_valid));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_word();
        exp_t e;
        for (int k = 0; k < 18; k++) begin
            e.f = ef[k];
            e.i = 5'(k);
            e.s = ((k / 3) % 2) == 1;
            e.l = k == 17;
            q.push_back(e);
        end
    endtask

    task automatic clear_ef();
        for (int k = 0; k < 18; k++) ef[k] = 8'h00;
    endtask

    task automatic send(input logic [89:0] w, input bit keep, output int t);
        in_valid = 1;
        in_y = w;
        t = 0;
        for (int n = 0; n < 100; n++) begin
            if (in_ready) begin
                t = cyc;
                @(posedge clk);
                #1;
                if (!keep) in_valid = 0;
                return;
            end
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL accept_timeout: in_ready never rose");
        in_valid = 0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!out_valid && q.size() == 0) return;
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: %0d fields still expected", q.size());
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sig_valid) pulses++;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_field: idx %0d field %0h with nothing expected", out_idx, out_field);
            end else begin
                e = q.pop_front();
                chk($sformatf("field[%0d] {f,idx,s,last}", e.i), {17'h0, out_field, out_idx, out_signed, out_last},
                    {17'h0, e.f, e.i, e.s, e.l});
                chk("in_ready_at_handshake", {31'h0, in_ready}, {31'h0, e.l});
                if (out_last) last_cyc = cyc;
            end
        end
    end

    initial begin
        int t, tb_, p0;
        bit hit;
        #12;
        chk("reset_outputs", {in_ready, out_valid, out_field, out_idx, out_signed, out_last, sig_valid, sig},
            {1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("idle_after_reset", {in_ready, out_valid}, {1'b1, 1'b0});
        // all ones
        for (int k = 0; k < 18; k++) ef[k] = ones_pat[k % 6];
        push_word();
        send({90{1'b1}}, 0, t);
        @(negedge clk);
        chk("latency_idx0", {out_valid, out_idx}, {1'b1, 5'd0});
        wait_idle();
        chk("ones_last_cycle", last_cyc - t, 18);
        // sign boundary
        clear_ef();
        ef[3] = 8'hF8;
        ef[4] = 8'h0F;
        push_word();
        send({15'h0, 4'b1000, 5'b01111, 66'h0}, 0, t);
        wait_idle();
        // backpressure at idx 7 on a mixed word
        clear_ef();
        ef[0] = 8'h0A; ef[1] = 8'h15; ef[2] = 8'h2A;
        ef[3] = 8'h05; ef[4] = 8'hF0; ef[5] = 8'hE0;
        ef[6] = 8'h09; ef[7] = 8'h0A; ef[8] = 8'h3C;
        ef[9] = 8'hFC; ef[10] = 8'hF1; ef[11] = 8'h05;
        push_word();
        send({4'hA, 5'h15, 6'h2A, 4'h5, 5'h10, 6'h20, 4'h9, 5'h0A, 6'h3C, 4'hC, 5'h11, 6'h05, 30'h0}, 0, t);
        hit = 0;
        for (int n = 0; n < 40 && !hit; n++) begin
            if (out_idx == 5'd7) begin
                out_ready = 0;
                hit = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("reached_idx7", {31'h0, hit}, 1);
        repeat (5) begin
            @(negedge clk);
            chk("backpressure_hold", {out_valid, out_idx, out_field}, {1'b1, 5'd7, 8'h0A});
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        wait_idle();
        // back-to-back: all ones then sign boundary
        for (int k = 0; k < 18; k++) ef[k] = ones_pat[k % 6];
        push_word();
        send({90{1'b1}}, 1, t);
        in_y = {15'h0, 4'b1000, 5'b01111, 66'h0};
        clear_ef();
        ef[3] = 8'hF8;
        ef[4] = 8'h0F;
        push_word();
        @(negedge clk);
        send({15'h0, 4'b1000, 5'b01111, 66'h0}, 0, tb_);
        wait_idle();
        chk("b2b_reload_cycle", tb_ - t, 18);
        chk("b2b_total_cycles", last_cyc - t, 36);
        // signature of 90'h1
        p0 = pulses;
        clear_ef();
        ef[17] = 8'h01;
        push_word();
        send(90'h1, 0, t);
        wait_idle();
        repeat (2) @(negedge clk);
`ifdef EXPR_UNPACK_SIG_EN
        chk("sig_value", {16'h0, sig}, 32'h0001);
        chk("sig_pulses", pulses - p0, 1);
`else
        chk("sig_tied_off", {15'h0, sig_valid, sig}, 0);
        chk("sig_pulses_off", pulses - p0, 0);
`endif
        // reset at idx 9 abandons the word
        p0 = pulses;
        push_word();
        send(90'h1, 0, t);
        hit = 0;
        for (int n = 0; n < 40 && !hit; n++) begin
            if (out_idx == 5'd9) hit = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("reached_idx9", {31'h0, hit}, 1);
        #2 rst_n = 0;
        #1;
        q.delete();
        chk("async_reset_state", {in_ready, out_valid, out_idx, out_field}, {1'b1, 1'b0, 5'd0, 8'h00});
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (25) @(negedge clk);
        chk("abandoned_word", {out_valid, in_ready, sig}, {1'b0, 1'b1, 16'h0000});
        chk("no_partial_sig_pulse", pulses - p0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
